// File: rtl/aftab_pkg.sv
// Shared encodings for the AFTAB load path: FSM states, load size codes and
// the last-byte index each size reads up to.
package aftab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] NB_BYTE = 2'b00;
    localparam logic [1:0] NB_HALF = 2'b01;
    localparam logic [1:0] NB_WORD = 2'b10;
    localparam logic [1:0] NB_RSVD = 2'b11;

    localparam logic [1:0] LAST_BYTE = 2'd0;
    localparam logic [1:0] LAST_HALF = 2'd1;
    localparam logic [1:0] LAST_WORD = 2'd3;

    // The reserved size code reads a full word.
    function automatic logic [1:0] last_index(input logic [1:0] nb);
        case (nb)
            NB_BYTE: last_index = LAST_BYTE;
            NB_HALF: last_index = LAST_HALF;
            default: last_index = LAST_WORD;
        endcase
    endfunction

endpackage

// File: rtl/aftab_load_extender.sv
// Combinational sign/zero extension of an assembled little-endian load buffer.
// Byte uses bit 7, half uses bit 15; word and the reserved code pass through.
module aftab_load_extender
    import aftab_pkg::*;
(
    input  logic [31:0] buffer,
    input  logic [1:0]  sizeCode,
    input  logic        unsignedLoad,
    output logic [31:0] dataOut
);

    always_comb begin
        dataOut = buffer;
        case (sizeCode)
            NB_BYTE: dataOut = {{24{~unsignedLoad & buffer[7]}},  buffer[7:0]};
            NB_HALF: dataOut = {{16{~unsignedLoad & buffer[15]}}, buffer[15:0]};
            default: dataOut = buffer;
        endcase
    end

endmodule

// File: rtl/aftab_load_assembler.sv
// Multi-cycle load unit: reads 1/2/4 bytes little-endian over a byte port, one byte per memReady,
// then pulses loadDone with the extended result; memReady low stalls READ, startLoad only taken in IDLE.
module aftab_load_assembler
    import aftab_pkg::*;
#(
    parameter int size      = 32,
    parameter int addrWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startLoad,
    input  logic [addrWidth-1:0] addrIn,
    input  logic [1:0]           nBytes,
    input  logic                 unsignedLoad,
    input  logic                 memReady,
    input  logic [7:0]           dataIn,
    output logic                 memRead,
    output logic [addrWidth-1:0] addrOut,
    output logic                 loadBusy,
    output logic                 loadDone,
    output logic [size-1:0]      dataOut
);

    state_t                 state;
    logic [1:0]             cnt;
    logic [1:0]             last_q;
    logic [1:0]             nb_q;
    logic                   uns_q;
    logic [addrWidth-1:0]   base_q;
    logic [31:0]            asm_buf;
    logic [31:0]            next_buf;
    logic [31:0]            ext_data;
    logic [1:0]             cnt_inc;

    assign cnt_inc = cnt + 2'd1;

    // The final byte is merged combinationally so the result can be
    // registered on the same edge that accepts it.
    always_comb begin
        next_buf = asm_buf;
        next_buf[{cnt, 3'b000} +: 8] = dataIn;
    end

    aftab_load_extender u_ext (
        .buffer       (next_buf),
        .sizeCode     (nb_q),
        .unsignedLoad (uns_q),
        .dataOut      (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            memRead  <= 1'b0;
            addrOut  <= '0;
            loadBusy <= 1'b0;
            loadDone <= 1'b0;
            dataOut  <= '0;
            cnt      <= 2'd0;
            asm_buf  <= '0;
            last_q   <= 2'd0;
            nb_q     <= 2'd0;
            uns_q    <= 1'b0;
            base_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    loadDone <= 1'b0;
                    if (startLoad) begin
                        base_q   <= addrIn;
                        nb_q     <= nBytes;
                        last_q   <= last_index(nBytes);
                        uns_q    <= unsignedLoad;
                        cnt      <= 2'd0;
                        asm_buf  <= '0;
                        addrOut  <= addrIn;
                        memRead  <= 1'b1;
                        loadBusy <= 1'b1;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (memReady) begin
                        asm_buf <= next_buf;
                        if (cnt == last_q) begin
                            dataOut  <= ext_data;
                            memRead  <= 1'b0;
                            loadDone <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            cnt     <= cnt_inc;
                            addrOut <= base_q + addrWidth'(cnt_inc);
                        end
                    end
                end
                ST_DONE: begin
                    loadDone <= 1'b0;
                    loadBusy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
